display_arbiter: RTL and testbench

Shares the single monitor RGB path between NUM_SRC independent video sources: game 1, game 2, and a menu/demo layer. It sits between the sources and the monitor port, fed by display_ctrl's h_coord, v_coord and disp_enbl. Ownership changes only at frame boundaries. A change is fair round-robin, or an explicit selection from the console. Every handover inserts BLANK_FRAMES black frames so no torn frame is shown.

---
 rtl/display_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/display_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_display_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/display_arb_pkg.sv
// display_arb_pkg: shared types and defaults for the display arbiter.
//   rgb444_t    - 12-bit packed {r,g,b} pixel, 4 bits per channel
//   arb_state_e - ownership FSM states
//   ID_W        - width of a source index (owner_id, sel_id)
package display_arb_pkg;

   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_V_ACTIVE = 600;
   localparam int ID_W         = 3;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      OWN   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick over a request mask.
//   clk, arst_n - clock, async active-low reset
//   req_mask_i  - candidate sources
//   upd_i       - record upd_idx_i as the last owner
//   upd_idx_i   - index just granted
//   win_idx_o   - first requester after the last owner (wrapping)
//   win_vld_o   - at least one candidate present
module rr_arbiter
   import display_arb_pkg::*;
#(
   parameter int NUM_SRC = 3
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic [NUM_SRC-1:0] req_mask_i,
   input  logic               upd_i,
   input  logic [ID_W-1:0]    upd_idx_i,
   output logic [ID_W-1:0]    win_idx_o,
   output logic               win_vld_o
);

   logic [ID_W-1:0] last_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) last_q <= '0;
      else if (upd_i) last_q <= upd_idx_i;
   end

   // Search positions last+1, last+2, ... wrapping; the last owner itself
   // is visited last, so it only wins when nobody else asks.
   always_comb begin
      int pos;
      pos       = 0;
      win_idx_o = '0;
      win_vld_o = 1'b0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         pos = (int'(last_q) + k) % NUM_SRC;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!win_vld_o && (i == pos) && req_mask_i[i]) begin
               win_vld_o = 1'b1;
               win_idx_o = ID_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: shares the monitor RGB path between NUM_SRC sources.
// Ownership only changes on the last active pixel of a frame, and every
// handover shows BLANK_FRAMES black frames first.
//   clk, arst_n         - pixel clock, async active-low reset
//   h_coord, v_coord    - pixel position from display_ctrl
//   disp_enbl           - active-video qualifier
//   req                 - per-source level request
//   sel_valid, sel_id   - explicit owner selection pulse
//   src_rgb             - packed 4:4:4 pixels, source i at [12i+11:12i]
//   monitor_r/g/b       - registered pixel out (1 clk latency)
//   grant, owner_id     - one-hot owner / its index (registered)
//   blanking            - high while no source is shown (IDLE or DRAIN)
module display_arbiter
   import display_arb_pkg::*;
#(
   parameter int NUM_SRC      = 3,
   parameter int H_ACTIVE     = DEF_H_ACTIVE,
   parameter int V_ACTIVE     = DEF_V_ACTIVE,
   parameter int BLANK_FRAMES = 2,
   parameter int MIN_FRAMES   = 4
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [10:0]           h_coord,
   input  logic [9:0]            v_coord,
   input  logic                  disp_enbl,
   input  logic [NUM_SRC-1:0]    req,
   input  logic                  sel_valid,
   input  logic [2:0]            sel_id,
   input  logic [NUM_SRC*12-1:0] src_rgb,
   output logic [3:0]            monitor_r,
   output logic [3:0]            monitor_g,
   output logic [3:0]            monitor_b,
   output logic [NUM_SRC-1:0]    grant,
   output logic [2:0]            owner_id,
   output logic                  blanking
);

   localparam logic [3:0] BLANK_LD = 4'(BLANK_FRAMES);
   localparam logic [7:0] MIN_LD   = 8'(MIN_FRAMES);

   arb_state_e         state_q;
   logic [NUM_SRC-1:0] grant_q;
   logic [ID_W-1:0]    owner_q, win_q, sel_id_q;
   logic               sel_pend_q, blank_q;
   logic [3:0]         drain_q;
   logic [7:0]         own_q, own_inc;
   rgb444_t            pix_q, pix_sel;

   logic               frame_end, drain_done;
   logic               owner_req, win_req, sel_tgt_req;
   logic               sel_in_ok, sel_eff_vld;
   logic [ID_W-1:0]    sel_eff_id;
   logic [NUM_SRC-1:0] arb_mask;
   logic [ID_W-1:0]    rr_idx;
   logic               rr_vld, rr_upd;

   assign frame_end = disp_enbl && (h_coord == 11'(H_ACTIVE - 1))
                                && (v_coord == 10'(V_ACTIVE - 1));

   // A select arriving on the frame_end cycle must take part in that
   // cycle's decision, so it bypasses the pending register here.
   assign sel_in_ok   = sel_valid && (int'(sel_id) < NUM_SRC);
   assign sel_eff_vld = sel_in_ok || sel_pend_q;
   assign sel_eff_id  = sel_in_ok ? sel_id : sel_id_q;

   assign own_inc    = (own_q >= MIN_LD) ? own_q : own_q + 8'd1;
   assign drain_done = (drain_q <= 4'd1);

   // While owning, arbitration only looks at the other sources.
   assign arb_mask = (state_q == OWN) ? (req & ~grant_q) : req;
   assign rr_upd   = frame_end && (state_q == DRAIN) && drain_done && win_req;

   always_comb begin
      owner_req   = 1'b0;
      win_req     = 1'b0;
      sel_tgt_req = 1'b0;
      pix_sel     = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (int'(owner_q) == i) begin
            owner_req = req[i];
            pix_sel   = src_rgb[12*i +: 12];
         end
         if (int'(win_q) == i)      win_req     = req[i];
         if (int'(sel_eff_id) == i) sel_tgt_req = req[i];
      end
   end

   rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
      .clk        (clk),
      .arst_n     (arst_n),
      .req_mask_i (arb_mask),
      .upd_i      (rr_upd),
      .upd_idx_i  (win_q),
      .win_idx_o  (rr_idx),
      .win_vld_o  (rr_vld)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         blank_q    <= 1'b1;
         win_q      <= '0;
         drain_q    <= '0;
         own_q      <= '0;
         sel_pend_q <= 1'b0;
         sel_id_q   <= '0;
      end else begin
         // Pending select: latest wins; selecting the current owner is a
         // no-op and drops whatever was pending.
         if (sel_in_ok) begin
            if ((state_q == OWN) && (sel_id == owner_q)) begin
               sel_pend_q <= 1'b0;
            end else begin
               sel_pend_q <= 1'b1;
               sel_id_q   <= sel_id;
            end
         end else if ((state_q == OWN) && (sel_id_q == owner_q)) begin
            sel_pend_q <= 1'b0;
         end

         if (frame_end) begin
            case (state_q)
               IDLE: begin
                  if (rr_vld) begin
                     win_q   <= rr_idx;
                     drain_q <= BLANK_LD;
                     state_q <= DRAIN;
                  end
               end
               DRAIN: begin
                  drain_q <= drain_done ? 4'd0 : drain_q - 4'd1;
                  if (drain_done) begin
                     // A winner that gave up during the black frames gets
                     // nothing; fall back and re-arbitrate from IDLE.
                     if (win_req) begin
                        state_q <= OWN;
                        grant_q <= NUM_SRC'(1) << win_q;
                        owner_q <= win_q;
                        own_q   <= '0;
                        blank_q <= 1'b0;
                     end else begin
                        state_q <= IDLE;
                     end
                  end
               end
               OWN: begin
                  own_q <= own_inc;
                  if (!owner_req) begin
                     grant_q <= '0;
                     blank_q <= 1'b1;
                     if (rr_vld) begin
                        win_q   <= rr_idx;
                        drain_q <= BLANK_LD;
                        state_q <= DRAIN;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else if (sel_eff_vld && (sel_eff_id != owner_q) && sel_tgt_req) begin
                     // Explicit select ignores the minimum hold time.
                     grant_q    <= '0;
                     blank_q    <= 1'b1;
                     win_q      <= sel_eff_id;
                     drain_q    <= BLANK_LD;
                     state_q    <= DRAIN;
                     sel_pend_q <= 1'b0;
                  end else if ((own_inc >= MIN_LD) && rr_vld) begin
                     grant_q <= '0;
                     blank_q <= 1'b1;
                     win_q   <= rr_idx;
                     drain_q <= BLANK_LD;
                     state_q <= DRAIN;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Pixel stage: black unless a source owns the screen and video is active.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) pix_q <= '0;
      else         pix_q <= ((state_q == OWN) && disp_enbl) ? pix_sel : '0;
   end

   assign monitor_r = pix_q.r;
   assign monitor_g = pix_q.g;
   assign monitor_b = pix_q.b;
   assign grant     = grant_q;
   assign owner_id  = owner_q;
   assign blanking  = blank_q;

endmodule

// File: tb/tb_display_arbiter.sv
module tb_display_arbiter;

   localparam int NS = 3;
   localparam int HA = 8;
   localparam int VA = 4;
   localparam int HT = 10;
   localparam int VT = 5;
   localparam int FR = HT * VT;

   logic          clk = 1'b0;
   logic          arst_n;
   logic [10:0]   h_coord;
   logic [9:0]    v_coord;
   logic          disp_enbl;
   logic [NS-1:0] req;
   logic          sel_valid;
   logic [2:0]    sel_id;
   logic [NS*12-1:0] src_rgb;
   logic [3:0]    monitor_r, monitor_g, monitor_b;
   logic [NS-1:0] grant;
   logic [2:0]    owner_id;
   logic          blanking;

   int errs   = 0;
   int checks = 0;
   int exp_own = -1;   // source expected on screen, -1 = black
   int hc = 0;
   int vc = 0;
   logic [11:0] pq[$];

   always #5 clk = ~clk;

   display_arbiter #(
      .NUM_SRC(NS), .H_ACTIVE(HA), .V_ACTIVE(VA),
      .BLANK_FRAMES(2), .MIN_FRAMES(4)
   ) dut (
      .clk(clk), .arst_n(arst_n), .h_coord(h_coord), .v_coord(v_coord),
      .disp_enbl(disp_enbl), .req(req), .sel_valid(sel_valid), .sel_id(sel_id),
      .src_rgb(src_rgb), .monitor_r(monitor_r), .monitor_g(monitor_g),
      .monitor_b(monitor_b), .grant(grant), .owner_id(owner_id), .blanking(blanking)
   );

   task automatic chk12(input string tag, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input int eo);
      logic [2:0] eg;
      logic       eb;
      eg = (eo < 0) ? 3'b000 : 3'(1 << eo);
      eb = (eo < 0);
      checks++;
      assert (grant === eg) else begin
         errs++;
         $error("FAIL %s grant got=%b exp=%b", tag, grant, eg);
      end
      checks++;
      assert (blanking === eb) else begin
         errs++;
         $error("FAIL %s blanking got=%b exp=%b", tag, blanking, eb);
      end
      if (eo >= 0) begin
         checks++;
         assert (owner_id === 3'(eo)) else begin
            errs++;
            $error("FAIL %s owner_id got=%0d exp=%0d", tag, owner_id, eo);
         end
      end
   endtask

   // One pixel clock: check the output caused by last cycle's inputs, then
   // drive the next raster position and queue the pixel it should produce.
   task automatic cyc();
      logic [11:0] e;
      @(negedge clk);
      if (pq.size() > 0) begin
         e = pq.pop_front();
         chk12("pix", {monitor_r, monitor_g, monitor_b}, e);
      end
      if (hc == HT - 1) begin
         hc = 0;
         vc = (vc == VT - 1) ? 0 : vc + 1;
      end else begin
         hc++;
      end
      h_coord   = 11'(hc);
      v_coord   = 10'(vc);
      disp_enbl = (hc < HA) && (vc < VA);
      src_rgb   = {4'($urandom), 32'($urandom)};
      e = 12'h000;
      if (exp_own >= 0 && disp_enbl) e = src_rgb[12*exp_own +: 12];
      pq.push_back(e);
   endtask

   // Run up to and through the next frame_end, then check control outputs.
   task automatic fe(input int new_own, input string tag);
      int n;
      cyc();
      n = 1;
      while (!(hc == HA - 1 && vc == VA - 1) && n < FR + 5) begin
         cyc();
         n++;
      end
      if (n >= FR + 5) begin
         checks++;
         errs++;
         $error("FAIL %s timeout waiting for frame end", tag);
      end
      exp_own = new_own;
      cyc();
      chk_ctl(tag, new_own);
   endtask

   task automatic pulse_sel(input logic [2:0] id);
      sel_valid = 1'b1;
      sel_id    = id;
      cyc();
      sel_valid = 1'b0;
   endtask

   initial begin
      arst_n = 1'b0; req = '0; sel_valid = 1'b0; sel_id = '0;
      h_coord = '0; v_coord = '0; disp_enbl = 1'b1; src_rgb = '0;
      repeat (3) cyc();
      chk_ctl("reset", -1);
      checks++;
      assert (owner_id === 3'd0) else begin
         errs++;
         $error("FAIL reset_owner got=%0d exp=0", owner_id);
      end
      chk12("reset_pix", {monitor_r, monitor_g, monitor_b}, 12'h000);
      arst_n = 1'b1;

      // first grant: two black frames then source 0
      req = 3'b001;
      fe(-1, "t1_fe1");
      fe(-1, "t1_fe2");
      fe(0, "t1_grant");
      cyc();
      chk12("hblank_own", {monitor_r, monitor_g, monitor_b}, 12'h000);

      // minimum hold then round-robin to source 1
      req = 3'b011;
      fe(0, "rr_hold1");
      fe(0, "rr_hold2");
      fe(0, "rr_hold3");
      fe(-1, "rr_drain1");
      fe(-1, "rr_drain2");
      fe(1, "rr_grant1");

      // owner drops mid-frame, source 0 takes over
      repeat (20) cyc();
      req = 3'b001;
      fe(-1, "drop_drain1");
      fe(-1, "drop_drain2");
      fe(0, "drop_grant0");

      // explicit select before MIN_FRAMES
      req = 3'b101;
      repeat (20) cyc();
      pulse_sel(3'd2);
      fe(-1, "sel_drain1");
      fe(-1, "sel_drain2");
      fe(2, "sel_grant2");

      // out-of-range select ignored; select of owner clears pending
      repeat (10) cyc();
      pulse_sel(3'd5);
      fe(2, "sel5_ignored");
      repeat (10) cyc();
      pulse_sel(3'd0);
      cyc();
      pulse_sel(3'd2);
      fe(2, "sel_own_clear");
      fe(2, "hold_own3");

      // owner leaves with nobody else asking
      repeat (10) cyc();
      req = 3'b000;
      fe(-1, "idle_drop");
      fe(-1, "idle_stay");

      // winner withdraws during the black frames
      req = 3'b001;
      fe(-1, "wd_drain1");
      req = 3'b000;
      fe(-1, "wd_drain2");
      fe(-1, "wd_idle");

      // asynchronous reset mid-line while owning
      req = 3'b001;
      fe(-1, "pre_drain1");
      fe(-1, "pre_drain2");
      fe(0, "pre_grant");
      repeat (15) cyc();
      #2 arst_n = 1'b0;
      #1;
      chk12("rst_pix", {monitor_r, monitor_g, monitor_b}, 12'h000);
      chk_ctl("rst_ctl", -1);
      pq.delete();
      exp_own = -1;
      cyc();
      arst_n = 1'b1;
      fe(-1, "rst_fe1");
      fe(-1, "rst_fe2");
      fe(0, "rst_regain");
      repeat (12) cyc();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
